// File: rtl/pe_array_ctrl.sv
// Sequencer for one systolic PE row: CLEAR -> K taps -> PIPE_LAT drain -> RESULT, once per pass.
// Optional abort (iAbort/oAborted) is built when PE_CTRL_ABORT_EN is defined.
module pe_array_ctrl #(
  parameter int ARRAY_NUM = 3,
  parameter int PIPE_LAT  = 5,
  parameter int PASS_W    = 16,
  localparam int KW = $clog2(ARRAY_NUM + 1),
  localparam int AW = (ARRAY_NUM > 1) ? $clog2(ARRAY_NUM) : 1
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic [KW-1:0]        iKernel,
  input  logic [PASS_W-1:0]    iPassCnt,
  input  logic [4:0]           iShift,
`ifdef PE_CTRL_ABORT_EN
  input  logic                 iAbort,
  output logic                 oAborted,
`endif
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oClearAcc,
  output logic [ARRAY_NUM-2:0] oCfsPassDataLeft,
  output logic [4:0]           oCfsOutputLeftShift,
  output logic                 oDataRdEn,
  output logic                 oWeightRdEn,
  output logic [AW-1:0]        oWeightAddr,
  output logic                 oResultValid,
  output logic [PASS_W-1:0]    oPassIdx
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_TAP    = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]        state_q, nxt_state;
  logic [AW-1:0]     t_q, nxt_t;
  logic [DW-1:0]     d_q, nxt_d;
  logic [PASS_W-1:0] pass_q, nxt_pass;
  logic [AW-1:0]     k_last_q;
  logic [PASS_W-1:0] pcnt_q;
  logic [KW-1:0]     k_san;
  logic              latch;
  logic              abort_hit;
  logic              nxt_tap;

  // Clamp the requested tap count into 1..ARRAY_NUM before it is latched.
  always_comb begin
    k_san = iKernel;
    if (iKernel == '0)
      k_san = KW'(1);
    else if (iKernel > KW'(ARRAY_NUM))
      k_san = KW'(ARRAY_NUM);
  end

  always_comb begin
    nxt_state = state_q;
    nxt_t     = t_q;
    nxt_d     = d_q;
    nxt_pass  = pass_q;
    latch     = 1'b0;
    abort_hit = 1'b0;
    case (state_q)
      ST_IDLE: if (iStart) begin
        latch     = 1'b1;
        nxt_pass  = '0;
        nxt_state = (iPassCnt == '0) ? ST_DONE : ST_CLEAR;
      end
      ST_CLEAR: begin
        nxt_t     = '0;
        nxt_state = ST_TAP;
      end
      ST_TAP: begin
        if (t_q == k_last_q) begin
          nxt_d     = '0;
          nxt_state = ST_DRAIN;
        end else begin
          nxt_t = t_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (d_q == DW'(PIPE_LAT - 1))
          nxt_state = ST_RESULT;
        else
          nxt_d = d_q + DW'(1);
      end
      ST_RESULT: begin
        if (pass_q == pcnt_q - PASS_W'(1)) begin
          nxt_state = ST_DONE;
        end else begin
          nxt_pass  = pass_q + PASS_W'(1);
          nxt_state = ST_CLEAR;
        end
      end
      ST_DONE: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
`ifdef PE_CTRL_ABORT_EN
    abort_hit = iAbort && (state_q != ST_IDLE) && (state_q != ST_DONE);
    if (abort_hit)
      nxt_state = ST_DONE;
`endif
  end

  assign nxt_tap = (nxt_state == ST_TAP);

  // Strobes are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q             <= ST_IDLE;
      t_q                 <= '0;
      d_q                 <= '0;
      pass_q              <= '0;
      k_last_q            <= '0;
      pcnt_q              <= '0;
      oCfsOutputLeftShift <= '0;
      oBusy               <= 1'b0;
      oDone               <= 1'b0;
      oClearAcc           <= 1'b0;
      oCfsPassDataLeft    <= '0;
      oDataRdEn           <= 1'b0;
      oWeightRdEn         <= 1'b0;
      oWeightAddr         <= '0;
      oResultValid        <= 1'b0;
      oPassIdx            <= '0;
`ifdef PE_CTRL_ABORT_EN
      oAborted            <= 1'b0;
`endif
    end else begin
      state_q <= nxt_state;
      t_q     <= nxt_t;
      d_q     <= nxt_d;
      pass_q  <= nxt_pass;
      if (latch) begin
        k_last_q            <= AW'(k_san - KW'(1));
        pcnt_q              <= iPassCnt;
        oCfsOutputLeftShift <= iShift;
      end
      oBusy            <= (nxt_state != ST_IDLE);
      oDone            <= (nxt_state == ST_DONE);
      oClearAcc        <= (nxt_state == ST_CLEAR);
      oDataRdEn        <= nxt_tap && (nxt_t == '0);
      oWeightRdEn      <= nxt_tap;
      oWeightAddr      <= nxt_tap ? nxt_t : '0;
      oCfsPassDataLeft <= (nxt_tap && (nxt_t != '0)) ? {(ARRAY_NUM-1){1'b1}} : '0;
      oResultValid     <= (nxt_state == ST_RESULT);
      oPassIdx         <= nxt_pass;
`ifdef PE_CTRL_ABORT_EN
      oAborted         <= abort_hit;
`endif
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized bench for pe_array_ctrl; expected strobes come from a cycle-offset arithmetic model.
module tb_pe_array_ctrl;
  localparam int AN = 3;
  localparam int PL = 5;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic [1:0]  iKernel;
  logic [15:0] iPassCnt;
  logic [4:0]  iShift;
  logic        oBusy, oDone, oClearAcc, oDataRdEn, oWeightRdEn, oResultValid;
  logic [1:0]  oCfsPassDataLeft;
  logic [4:0]  oCfsOutputLeftShift;
  logic [1:0]  oWeightAddr;
  logic [15:0] oPassIdx;
`ifdef PE_CTRL_ABORT_EN
  logic        iAbort;
  logic        oAborted;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 iClk = ~iClk;

  pe_array_ctrl #(.ARRAY_NUM(AN), .PIPE_LAT(PL), .PASS_W(16)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iKernel(iKernel),
    .iPassCnt(iPassCnt), .iShift(iShift),
`ifdef PE_CTRL_ABORT_EN
    .iAbort(iAbort), .oAborted(oAborted),
`endif
    .oBusy(oBusy), .oDone(oDone), .oClearAcc(oClearAcc),
    .oCfsPassDataLeft(oCfsPassDataLeft), .oCfsOutputLeftShift(oCfsOutputLeftShift),
    .oDataRdEn(oDataRdEn), .oWeightRdEn(oWeightRdEn), .oWeightAddr(oWeightAddr),
    .oResultValid(oResultValid), .oPassIdx(oPassIdx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected {busy,done,clr,drd,wrd,waddr,mask,rv,idx} at cycle n after the start edge.
  function automatic logic [25:0] model(int k, int p, int n, int ab);
    int ke, L, m;
    logic busy, done, clr, drd, wrd, rv;
    logic [1:0] wa, mk;
    logic [15:0] idx;
    {busy, done, clr, drd, wrd, rv} = '0;
    wa = '0; mk = '0; idx = '0;
    ke = (k == 0) ? 1 : ((k > AN) ? AN : k);
    L  = ke + PL + 2;
    if (ab > 0 && n > ab) begin
      if (n == ab + 1) begin busy = 1; done = 1; end
    end else if (p == 0) begin
      if (n == 1) begin busy = 1; done = 1; end
    end else if (n >= 1 && n <= p * L) begin
      m = (n - 1) % L;
      busy = 1;
      if (m == 0) clr = 1;
      else if (m <= ke) begin
        wrd = 1;
        wa  = 2'(m - 1);
        drd = (m == 1);
        mk  = (m == 1) ? 2'b00 : 2'b11;
      end else if (m == L - 1) begin
        rv  = 1;
        idx = 16'((n - 1) / L);
      end
    end else if (n == p * L + 1) begin
      busy = 1; done = 1;
    end
    return {busy, done, clr, drd, wrd, wa, mk, rv, idx};
  endfunction

  function automatic logic [25:0] observed();
    return {oBusy, oDone, oClearAcc, oDataRdEn, oWeightRdEn,
            oWeightRdEn ? oWeightAddr : 2'b00, oCfsPassDataLeft,
            oResultValid, oResultValid ? oPassIdx : 16'h0};
  endfunction

  // Start a job, then check every cycle until a couple of idle cycles after DONE.
  task automatic run_job(input int k, input int p, input logic [4:0] sh, input int ab,
                         input bit noise);
    int ke, total;
    ke = (k == 0) ? 1 : ((k > AN) ? AN : k);
    total = (p == 0) ? 1 : p * (ke + PL + 2) + 1;
    if (ab > 0) total = ab + 1;
    @(negedge iClk);
    iStart = 1'b1; iKernel = k[1:0]; iPassCnt = p[15:0]; iShift = sh;
    for (int n = 1; n <= total + 2; n++) begin
      @(negedge iClk);
      iStart = 1'b0;
`ifdef PE_CTRL_ABORT_EN
      iAbort = 1'b0;
      chk($sformatf("abrt k%0d p%0d c%0d", k, p, n), 32'(oAborted),
          32'(ab > 0 && n == ab + 1));
`endif
      chk($sformatf("cyc k%0d p%0d c%0d", k, p, n), 32'(observed()), 32'(model(k, p, n, ab)));
      chk($sformatf("shift c%0d", n), 32'(oCfsOutputLeftShift), 32'(sh));
      if (noise && p > 0 && (n == 2 || n == ke + 3)) begin
        iStart = 1'b1;
        iKernel = 2'($urandom_range(0, 3));
        iPassCnt = 16'($urandom_range(0, 9));
        iShift = ~sh;
      end
`ifdef PE_CTRL_ABORT_EN
      if (ab > 0 && n == ab) iAbort = 1'b1;
`endif
    end
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iKernel = '0; iPassCnt = '0; iShift = '0;
`ifdef PE_CTRL_ABORT_EN
    iAbort = 1'b0;
`endif
    repeat (2) @(negedge iClk);
    chk("reset", 32'(observed()), 32'h0);
    chk("reset shift", 32'(oCfsOutputLeftShift), 32'h0);
    iRst = 1'b0;
    @(negedge iClk);
    chk("idle", 32'(observed()), 32'h0);

    run_job(3, 2, 5'd4, 0, 1'b0);
    run_job(1, 1, 5'd9, 0, 1'b0);
    run_job(0, 2, 5'd1, 0, 1'b0);
    run_job(7, 1, 5'd31, 0, 1'b0);
    run_job(2, 0, 5'd7, 0, 1'b0);
    run_job(3, 3, 5'd12, 0, 1'b1);

    // Reset at c6 of a running job: quiet at c7, no DONE pulse.
    @(negedge iClk);
    iStart = 1'b1; iKernel = 2'd3; iPassCnt = 16'd2; iShift = 5'd4;
    for (int n = 1; n <= 8; n++) begin
      @(negedge iClk);
      iStart = 1'b0;
      iRst = 1'b0;
      if (n <= 6)
        chk($sformatf("prerst c%0d", n), 32'(observed()), 32'(model(3, 2, n, 0)));
      else begin
        chk($sformatf("rst c%0d", n), 32'(observed()), 32'h0);
        chk($sformatf("rst shift c%0d", n), 32'(oCfsOutputLeftShift), 32'h0);
      end
      if (n == 6) iRst = 1'b1;
    end
    run_job(2, 2, 5'd3, 0, 1'b0);

`ifdef PE_CTRL_ABORT_EN
    run_job(3, 4, 5'd6, 13, 1'b0);
    run_job(1, 1, 5'd2, 0, 1'b0);
`endif

    for (int r = 0; r < 20; r++)
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              5'($urandom_range(0, 31)), 0, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
